// File: rtl/router_pkt_fifo.sv
// router_pkt_fifo: packet-aware output FIFO for one port of the 1x3 router.
//
// Each stored word carries a header flag, taken from lfd_r when the word is
// pushed. The read side uses that flag and the length field of header words
// to track packet progress. It reports pkt_active while a packet is partly
// read, and raises pkt_done for one cycle after the last word of a packet
// has been popped.
//
// Optional feature macro: ROUTER_FIFO_OVF_FLAG_EN
//   defined   : overflow is a sticky flag, set by a write attempted while full.
//   undefined : overflow is tied to 0 and no register is built for it.
//
// Ports:
//   clock       rising-edge clock
//   reset_n     synchronous active-low reset (highest priority)
//   soft_reset  synchronous flush from the router FSM timeout
//   write_en    push request (dropped while full)
//   read_en     pop request (ignored while empty)
//   lfd_state   high in the cycle before a header word is written
//   data_in     write data
//   data_out    registered read data, holds its value between pops
//   empty       FIFO holds no words
//   full        FIFO holds 2^DEPTH_LOG2 words
//   count       occupancy, 0 .. 2^DEPTH_LOG2
//   pkt_active  a packet is partly read
//   pkt_done    one-cycle pulse after the last word of a packet is popped
//   overflow    sticky write-while-full flag (0 unless the macro is defined)
module router_pkt_fifo #(
    parameter int unsigned DATA_W     = 8,
    parameter int unsigned DEPTH_LOG2 = 4,
    parameter int unsigned LEN_LSB    = 2
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  soft_reset,
    input  logic                  write_en,
    input  logic                  read_en,
    input  logic                  lfd_state,
    input  logic [DATA_W-1:0]     data_in,
    output logic [DATA_W-1:0]     data_out,
    output logic                  empty,
    output logic                  full,
    output logic [DEPTH_LOG2:0]   count,
    output logic                  pkt_active,
    output logic                  pkt_done,
    output logic                  overflow
);

    localparam int unsigned DEPTH   = 1 << DEPTH_LOG2;
    localparam int unsigned PTR_W   = DEPTH_LOG2 + 1;
    localparam int unsigned ENTRY_W = DATA_W + 1;
    localparam int unsigned LEN_W   = DATA_W - LEN_LSB;
    localparam int unsigned REM_W   = LEN_W + 1;

    // Storage: each entry is {hdr, data}
    logic [ENTRY_W-1:0] mem [DEPTH];

    logic [PTR_W-1:0]   wptr;
    logic [PTR_W-1:0]   rptr;
    logic [REM_W-1:0]   remain;
    logic               lfd_r;

    logic               clear;
    logic               push;
    logic               pop;
    logic [ENTRY_W-1:0] rd_entry;
    logic               rd_hdr;
    logic [DATA_W-1:0]  rd_data;
    logic [LEN_W-1:0]   rd_len;

    // Reset and flush clear the same state; both override push and pop
    assign clear = !reset_n || soft_reset;
    assign push  = !clear && write_en && !full;
    assign pop   = !clear && read_en && !empty;

    // Head-of-queue entry and its fields
    assign rd_entry          = mem[rptr[DEPTH_LOG2-1:0]];
    assign {rd_hdr, rd_data} = rd_entry;
    assign rd_len            = rd_data[DATA_W-1:LEN_LSB];

    // Status derived from registers; the extra pointer bit separates full from empty
    assign empty      = (wptr == rptr);
    assign full       = (wptr[PTR_W-1] != rptr[PTR_W-1]) &&
                        (wptr[DEPTH_LOG2-1:0] == rptr[DEPTH_LOG2-1:0]);
    assign count      = wptr - rptr;
    assign pkt_active = (remain != '0);

    // Memory array is not reset; stale contents are never read past wptr
    always_ff @(posedge clock) begin
        if (push) begin
            mem[wptr[DEPTH_LOG2-1:0]] <= {lfd_r, data_in};
        end
    end

    // Header-flag register: delays lfd_state so it lines up with the header push
    always_ff @(posedge clock) begin
        if (clear) begin
            lfd_r <= 1'b0;
        end else begin
            lfd_r <= lfd_state;
        end
    end

    // Write and read pointers
    always_ff @(posedge clock) begin
        if (clear) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (push) begin
                wptr <= wptr + PTR_W'(1);
            end
            if (pop) begin
                rptr <= rptr + PTR_W'(1);
            end
        end
    end

    // Read data and packet tracking.
    // A header reloads remain with len+1 (payload plus parity) even when the
    // previous packet was truncated, so a truncated packet never pulses done.
    // Non-header words outside a packet pass through with remain left at 0.
    always_ff @(posedge clock) begin
        if (clear) begin
            data_out <= '0;
            remain   <= '0;
            pkt_done <= 1'b0;
        end else begin
            pkt_done <= 1'b0;
            if (pop) begin
                data_out <= rd_data;
                if (rd_hdr) begin
                    remain <= REM_W'(rd_len) + REM_W'(1);
                end else if (remain != '0) begin
                    remain   <= remain - REM_W'(1);
                    pkt_done <= (remain == REM_W'(1));
                end
            end
        end
    end

`ifdef ROUTER_FIFO_OVF_FLAG_EN
    logic overflow_r;

    // Sticky write-while-full flag
    always_ff @(posedge clock) begin
        if (clear) begin
            overflow_r <= 1'b0;
        end else if (write_en && full) begin
            overflow_r <= 1'b1;
        end
    end

    assign overflow = overflow_r;
`else
    assign overflow = 1'b0;
`endif

endmodule

// File: tb/tb_router_pkt_fifo.sv
// Directed self-checking bench for router_pkt_fifo (DATA_W=8, depth 16).
module tb_router_pkt_fifo;

    localparam int unsigned DATA_W     = 8;
    localparam int unsigned DEPTH_LOG2 = 4;
    localparam int unsigned LEN_LSB    = 2;

`ifdef ROUTER_FIFO_OVF_FLAG_EN
    localparam logic OVF_EXP = 1'b1;
`else
    localparam logic OVF_EXP = 1'b0;
`endif

    logic                clock = 1'b0;
    logic                reset_n;
    logic                soft_reset;
    logic                write_en;
    logic                read_en;
    logic                lfd_state;
    logic [DATA_W-1:0]   data_in;
    logic [DATA_W-1:0]   data_out;
    logic                empty;
    logic                full;
    logic [DEPTH_LOG2:0] count;
    logic                pkt_active;
    logic                pkt_done;
    logic                overflow;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    router_pkt_fifo #(
        .DATA_W     (DATA_W),
        .DEPTH_LOG2 (DEPTH_LOG2),
        .LEN_LSB    (LEN_LSB)
    ) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .soft_reset (soft_reset),
        .write_en   (write_en),
        .read_en    (read_en),
        .lfd_state  (lfd_state),
        .data_in    (data_in),
        .data_out   (data_out),
        .empty      (empty),
        .full       (full),
        .count      (count),
        .pkt_active (pkt_active),
        .pkt_done   (pkt_done),
        .overflow   (overflow)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Apply inputs, take one rising edge, then settle before sampling
    task automatic drive(input logic we, input logic re, input logic lfd, input logic [7:0] din);
        write_en  = we;
        read_en   = re;
        lfd_state = lfd;
        data_in   = din;
        @(posedge clock);
        #1;
    endtask

    logic [7:0] pkt1 [5];
    logic [7:0] pkt2 [6];
    logic [7:0] trunc [6];
    int         done_seen;

    initial begin
        pkt1  = '{8'h0D, 8'hA1, 8'hA2, 8'hA3, 8'hCF};
        pkt2  = '{8'h11, 8'hB1, 8'hB2, 8'hB3, 8'hB4, 8'h77};
        trunc = '{8'h11, 8'hC1, 8'hC2, 8'h05, 8'hD1, 8'hD2};

        // Reset
        reset_n    = 1'b0;
        soft_reset = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 8'h00);
        check("rst_empty", 32'(empty), 32'd1);
        check("rst_full", 32'(full), 32'd0);
        check("rst_count", 32'(count), 32'd0);
        check("rst_data_out", 32'(data_out), 32'd0);
        check("rst_pkt_active", 32'(pkt_active), 32'd0);
        check("rst_pkt_done", 32'(pkt_done), 32'd0);
        check("rst_overflow", 32'(overflow), 32'd0);
        reset_n = 1'b1;

        // Single packet: header 0x0D (len 3), three payload words, parity
        drive(1'b0, 1'b0, 1'b1, 8'h00);
        for (int i = 0; i < 5; i++) drive(1'b1, 1'b0, 1'b0, pkt1[i]);
        check("p1_count", 32'(count), 32'd5);
        check("p1_empty", 32'(empty), 32'd0);
        for (int i = 0; i < 5; i++) begin
            drive(1'b0, 1'b1, 1'b0, 8'h00);
            check($sformatf("p1_data%0d", i), 32'(data_out), 32'(pkt1[i]));
            check($sformatf("p1_active%0d", i), 32'(pkt_active), (i < 4) ? 32'd1 : 32'd0);
            check($sformatf("p1_done%0d", i), 32'(pkt_done), (i == 4) ? 32'd1 : 32'd0);
        end
        drive(1'b0, 1'b0, 1'b0, 8'h00);
        check("p1_done_pulse_end", 32'(pkt_done), 32'd0);
        check("p1_empty_end", 32'(empty), 32'd1);
        check("p1_data_hold", 32'(data_out), 32'hCF);

        // Fill to full with non-header words
        for (int i = 0; i < 16; i++) begin
            drive(1'b1, 1'b0, 1'b0, 8'(i));
            check($sformatf("fill_count%0d", i), 32'(count), 32'(i + 1));
        end
        check("fill_full", 32'(full), 32'd1);
        drive(1'b1, 1'b0, 1'b0, 8'hFF);
        check("drop_count", 32'(count), 32'd16);
        check("drop_full", 32'(full), 32'd1);
        check("drop_overflow", 32'(overflow), 32'(OVF_EXP));

        // Pop 4 (pass-through, no packet), push 4 across the wrap
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 1'b1, 1'b0, 8'h00);
            check($sformatf("wrap_pop%0d", i), 32'(data_out), 32'(i));
            check($sformatf("wrap_active%0d", i), 32'(pkt_active), 32'd0);
        end
        for (int i = 0; i < 4; i++) drive(1'b1, 1'b0, 1'b0, 8'(8'h10 + i));
        check("wrap_full", 32'(full), 32'd1);
        check("wrap_count", 32'(count), 32'd16);

        // Push and pop together while full: only the pop happens
        drive(1'b1, 1'b1, 1'b0, 8'hEE);
        check("both_full_count", 32'(count), 32'd15);
        check("both_full_data", 32'(data_out), 32'h04);
        check("both_full_full", 32'(full), 32'd0);
        for (int i = 5; i <= 8'h13; i++) begin
            drive(1'b0, 1'b1, 1'b0, 8'h00);
            check($sformatf("drain_data%0d", i), 32'(data_out), 32'(i));
        end
        check("drain_empty", 32'(empty), 32'd1);
        check("drain_count", 32'(count), 32'd0);

        // Push and pop together while empty: only the push happens
        drive(1'b1, 1'b1, 1'b0, 8'h55);
        check("both_empty_count", 32'(count), 32'd1);
        check("both_empty_data", 32'(data_out), 32'h13);
        drive(1'b0, 1'b1, 1'b0, 8'h00);
        check("both_empty_pop", 32'(data_out), 32'h55);
        check("both_empty_empty", 32'(empty), 32'd1);
        check("ovf_sticky", 32'(overflow), 32'(OVF_EXP));

        // Soft reset mid-packet (6-word packet, header 0x11 len 4)
        drive(1'b0, 1'b0, 1'b1, 8'h00);
        for (int i = 0; i < 6; i++) drive(1'b1, 1'b0, 1'b0, pkt2[i]);
        for (int i = 0; i < 2; i++) begin
            drive(1'b0, 1'b1, 1'b0, 8'h00);
            check($sformatf("sr_pop%0d", i), 32'(data_out), 32'(pkt2[i]));
        end
        check("sr_active_before", 32'(pkt_active), 32'd1);
        check("sr_count_before", 32'(count), 32'd4);
        soft_reset = 1'b1;
        drive(1'b0, 1'b1, 1'b0, 8'h00);
        soft_reset = 1'b0;
        check("sr_empty", 32'(empty), 32'd1);
        check("sr_count", 32'(count), 32'd0);
        check("sr_active", 32'(pkt_active), 32'd0);
        check("sr_data_out", 32'(data_out), 32'd0);
        check("sr_overflow", 32'(overflow), 32'd0);
        check("sr_done", 32'(pkt_done), 32'd0);

        // Truncated packet: header 0x11 (len 4), 2 words, then header 0x05 (len 1)
        drive(1'b0, 1'b0, 1'b1, 8'h00);
        drive(1'b1, 1'b0, 1'b0, trunc[0]);
        drive(1'b1, 1'b0, 1'b0, trunc[1]);
        drive(1'b1, 1'b0, 1'b1, trunc[2]);
        drive(1'b1, 1'b0, 1'b0, trunc[3]);
        drive(1'b1, 1'b0, 1'b0, trunc[4]);
        drive(1'b1, 1'b0, 1'b0, trunc[5]);
        check("tr_count", 32'(count), 32'd6);
        done_seen = 0;
        for (int i = 0; i < 6; i++) begin
            drive(1'b0, 1'b1, 1'b0, 8'h00);
            if (pkt_done === 1'b1) done_seen++;
            check($sformatf("tr_data%0d", i), 32'(data_out), 32'(trunc[i]));
            check($sformatf("tr_active%0d", i), 32'(pkt_active), (i < 5) ? 32'd1 : 32'd0);
            check($sformatf("tr_done%0d", i), 32'(pkt_done), (i == 5) ? 32'd1 : 32'd0);
        end
        drive(1'b0, 1'b0, 1'b0, 8'h00);
        if (pkt_done === 1'b1) done_seen++;
        check("tr_done_total", 32'(done_seen), 32'd1);

        // Hard reset mid-packet abandons the packet
        drive(1'b0, 1'b0, 1'b1, 8'h00);
        drive(1'b1, 1'b0, 1'b0, 8'h09);
        drive(1'b1, 1'b0, 1'b0, 8'hE1);
        drive(1'b0, 1'b1, 1'b0, 8'h00);
        check("hr_active_before", 32'(pkt_active), 32'd1);
        reset_n = 1'b0;
        drive(1'b0, 1'b1, 1'b0, 8'h00);
        reset_n = 1'b1;
        check("hr_active", 32'(pkt_active), 32'd0);
        check("hr_empty", 32'(empty), 32'd1);
        check("hr_data_out", 32'(data_out), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
